// File: rtl/ball_depth_sequencer.sv
// ball_depth_sequencer
//   Frame-synchronous configuration sequencer for the ball sprite renderer.
//   Game logic writes a ball position (x, y, z) over a req/ack handshake.
//   An iterative subtract-by-ZONE_DEPTH loop resolves the depth zone. Table
//   lookups then produce the top-left origin, the bounds and the ROM line
//   stride. The result is staged and reaches the renderer outputs only on an
//   idle cycle with vblank high, so a frame never sees a half-updated sprite.
//
//   Optional feature: define BALL_CLAMP_EN to clamp trans_x/trans_y to 0 when
//   the centre is left of / above HALF[zone]. The bounds are not affected.
//   Without the macro, trans wraps modulo 2^COORD_W.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   wr_req         position write request, held until wr_ack
//   wr_x/wr_y/wr_z ball centre x/y and depth z
//   wr_ack         one-cycle acknowledge; the position is captured on that edge
//   vblank         high during vertical blanking (commit window)
//   busy           zone resolution or table lookup in progress
//   cfg_valid      at least one configuration committed since reset
//   cfg_update     one-cycle pulse on each commit
//   zone           committed depth zone
//   trans_x/y      committed top-left corner
//   x_bound/y_bound  committed top-left + STAGE[zone]
//   line_stride    STAGE[zone] + 1, the ROM address increment per sprite line
module ball_depth_sequencer #(
  parameter int ZONE_DEPTH = 50,
  parameter int NUM_ZONES  = 20,
  parameter int COORD_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_req,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [COORD_W-1:0] wr_z,
  output logic               wr_ack,
  input  logic               vblank,
  output logic               busy,
  output logic               cfg_valid,
  output logic               cfg_update,
  output logic [4:0]         zone,
  output logic [COORD_W-1:0] trans_x,
  output logic [COORD_W-1:0] trans_y,
  output logic [COORD_W-1:0] x_bound,
  output logic [COORD_W-1:0] y_bound,
  output logic [12:0]        line_stride
);

  typedef enum logic [1:0] {IDLE, ZONE, LOOKUP} state_t;

  // Sprite edge length for each depth zone.
  function automatic logic [6:0] stage_of(input logic [4:0] idx);
    case (idx)
      5'd0:  stage_of = 7'd69;
      5'd1:  stage_of = 7'd60;
      5'd2:  stage_of = 7'd53;
      5'd3:  stage_of = 7'd48;
      5'd4:  stage_of = 7'd43;
      5'd5:  stage_of = 7'd39;
      5'd6:  stage_of = 7'd36;
      5'd7:  stage_of = 7'd33;
      5'd8:  stage_of = 7'd31;
      5'd9:  stage_of = 7'd29;
      5'd10: stage_of = 7'd27;
      5'd11: stage_of = 7'd26;
      5'd12: stage_of = 7'd24;
      5'd13: stage_of = 7'd23;
      5'd14: stage_of = 7'd22;
      5'd15: stage_of = 7'd21;
      5'd16: stage_of = 7'd20;
      5'd17: stage_of = 7'd19;
      5'd18: stage_of = 7'd18;
      default: stage_of = 7'd17;
    endcase
  endfunction

  // Centre-to-edge offset for each depth zone.
  function automatic logic [5:0] half_of(input logic [4:0] idx);
    case (idx)
      5'd0:  half_of = 6'd34;
      5'd1:  half_of = 6'd29;
      5'd2:  half_of = 6'd26;
      5'd3:  half_of = 6'd23;
      5'd4:  half_of = 6'd21;
      5'd5:  half_of = 6'd19;
      5'd6:  half_of = 6'd17;
      5'd7:  half_of = 6'd16;
      5'd8:  half_of = 6'd15;
      5'd9:  half_of = 6'd14;
      5'd10: half_of = 6'd13;
      5'd11: half_of = 6'd12;
      5'd12: half_of = 6'd11;
      5'd13: half_of = 6'd11;
      5'd14: half_of = 6'd10;
      5'd15: half_of = 6'd10;
      5'd16: half_of = 6'd9;
      5'd17: half_of = 6'd9;
      default: half_of = 6'd8;
    endcase
  endfunction

  state_t             state;
  logic [COORD_W-1:0] shadow_x, shadow_y;
  logic [COORD_W-1:0] rem;
  logic [4:0]         zone_cnt;

  logic               staged;
  logic [4:0]         stg_zone;
  logic [COORD_W-1:0] stg_tx, stg_ty, stg_bx, stg_by;
  logic [12:0]        stg_stride;

  logic               capture;
  logic               commit;
  logic [COORD_W-1:0] half_w, stage_w;
  logic [COORD_W-1:0] tx_raw, ty_raw, tx_new, ty_new, bx_new, by_new;

  assign capture = wr_req && !wr_ack;
  assign commit  = staged && vblank && (state == IDLE);
  assign busy    = (state != IDLE);

  // Lookup arithmetic for the zone currently held in zone_cnt.
  always_comb begin
    half_w  = COORD_W'(half_of(zone_cnt));
    stage_w = COORD_W'(stage_of(zone_cnt));
    tx_raw  = shadow_x - half_w;
    ty_raw  = shadow_y - half_w;
    // Bounds always use the unclamped origin so the sprite keeps its size.
    bx_new  = tx_raw + stage_w;
    by_new  = ty_raw + stage_w;
`ifdef BALL_CLAMP_EN
    tx_new  = (shadow_x < half_w) ? '0 : tx_raw;
    ty_new  = (shadow_y < half_w) ? '0 : ty_raw;
`else
    tx_new  = tx_raw;
    ty_new  = ty_raw;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ack      <= 1'b0;
      shadow_x    <= '0;
      shadow_y    <= '0;
      rem         <= '0;
      zone_cnt    <= '0;
      staged      <= 1'b0;
      stg_zone    <= '0;
      stg_tx      <= '0;
      stg_ty      <= '0;
      stg_bx      <= '0;
      stg_by      <= '0;
      stg_stride  <= '0;
      cfg_valid   <= 1'b0;
      cfg_update  <= 1'b0;
      zone        <= '0;
      trans_x     <= '0;
      trans_y     <= '0;
      x_bound     <= '0;
      y_bound     <= '0;
      line_stride <= '0;
    end else begin
      wr_ack     <= 1'b0;
      cfg_update <= 1'b0;

      // Commit stage: staging -> renderer outputs, only while idle in blanking.
      if (commit) begin
        zone        <= stg_zone;
        trans_x     <= stg_tx;
        trans_y     <= stg_ty;
        x_bound     <= stg_bx;
        y_bound     <= stg_by;
        line_stride <= stg_stride;
        staged      <= 1'b0;
        cfg_update  <= 1'b1;
        cfg_valid   <= 1'b1;
      end

      // Compute stage: iterative zone resolution then one lookup cycle.
      case (state)
        ZONE: begin
          if ((rem >= COORD_W'(ZONE_DEPTH)) && (zone_cnt < 5'(NUM_ZONES - 1))) begin
            rem      <= rem - COORD_W'(ZONE_DEPTH);
            zone_cnt <= zone_cnt + 5'd1;
          end else begin
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          // A write arriving now supersedes this result, so it is not staged.
          if (!capture) begin
            stg_zone   <= zone_cnt;
            stg_tx     <= tx_new;
            stg_ty     <= ty_new;
            stg_bx     <= bx_new;
            stg_by     <= by_new;
            stg_stride <= 13'(stage_of(zone_cnt)) + 13'd1;
            staged     <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Capture stage: a new write always restarts zone resolution.
      if (capture) begin
        wr_ack   <= 1'b1;
        shadow_x <= wr_x;
        shadow_y <= wr_y;
        rem      <= wr_z;
        zone_cnt <= '0;
        state    <= ZONE;
      end
    end
  end

endmodule

// File: tb/tb_ball_depth_sequencer.sv
// tb_ball_depth_sequencer
//   Directed and randomized checks of ball_depth_sequencer against a
//   behavioural model: zone = min(z / 50, 19), table lookups for HALF/STAGE,
//   cycle counts derived from zone, commit gated by vblank.
module tb_ball_depth_sequencer;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [CW-1:0] wr_x, wr_y, wr_z;
  logic          wr_ack;
  logic          vblank;
  logic          busy, cfg_valid, cfg_update;
  logic [4:0]    zone;
  logic [CW-1:0] trans_x, trans_y, x_bound, y_bound;
  logic [12:0]   line_stride;

  ball_depth_sequencer #(.ZONE_DEPTH(50), .NUM_ZONES(20), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z),
    .wr_ack(wr_ack), .vblank(vblank), .busy(busy), .cfg_valid(cfg_valid),
    .cfg_update(cfg_update), .zone(zone), .trans_x(trans_x), .trans_y(trans_y),
    .x_bound(x_bound), .y_bound(y_bound), .line_stride(line_stride)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int stage_t[20] = '{69,60,53,48,43,39,36,33,31,29,27,26,24,23,22,21,20,19,18,17};
  int half_t[20]  = '{34,29,26,23,21,19,17,16,15,14,13,12,11,11,10,10,9,9,8,8};

  int e_zone, e_tx, e_ty, e_bx, e_by, e_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int x, input int y, input int z);
    int h, s;
    e_zone = z / 50;
    if (e_zone > 19) e_zone = 19;
    h = half_t[e_zone];
    s = stage_t[e_zone];
    e_tx = (x - h) & 32'hFFFF;
    e_ty = (y - h) & 32'hFFFF;
    e_bx = (x - h + s) & 32'hFFFF;
    e_by = (y - h + s) & 32'hFFFF;
    e_st = s + 1;
`ifdef BALL_CLAMP_EN
    if (x < h) e_tx = 0;
    if (y < h) e_ty = 0;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_zone"},   zone,        e_zone);
    chk({tag, "_tx"},     trans_x,     e_tx);
    chk({tag, "_ty"},     trans_y,     e_ty);
    chk({tag, "_bx"},     x_bound,     e_bx);
    chk({tag, "_by"},     y_bound,     e_by);
    chk({tag, "_stride"}, line_stride, e_st);
    chk({tag, "_valid"},  cfg_valid,   1);
  endtask

  // Request held through the ack cycle: exactly one ack is expected.
  task automatic send(input int x, input int y, input int z, output int nb, output int nu);
    nb = 0; nu = 0;
    wr_x = CW'(x); wr_y = CW'(y); wr_z = CW'(z); wr_req = 1'b1;
    step;
    chk("ack_first", wr_ack, 1);
    nb += int'(busy); nu += int'(cfg_update);
    step;
    chk("ack_once", wr_ack, 0);
    nb += int'(busy); nu += int'(cfg_update);
    wr_req = 1'b0;
  endtask

  task automatic wait_upd(input int maxc, output int cyc, output int nb);
    cyc = 0; nb = 0;
    while (1) begin
      step;
      cyc++;
      nb += int'(busy);
      if (cfg_update) break;
      if (cyc >= maxc) begin
        chk("upd_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic run_one(input string tag, input int x, input int y, input int z);
    int nb1, nu, cyc, nb2;
    model(x, y, z);
    send(x, y, z, nb1, nu);
    wait_upd(60, cyc, nb2);
    chk({tag, "_busy_cycles"}, nb1 + nb2, e_zone + 2);
    chk({tag, "_latency"}, cyc, e_zone + 2);
    chk({tag, "_early_upd"}, nu, 0);
    check_outputs(tag);
    step;
    chk({tag, "_upd_pulse"}, cfg_update, 0);
  endtask

  initial begin
    int nb, nu, nu2, cyc, p_tx, p_zone, a_tx, a_zone;
    rst = 1'b1; wr_req = 1'b0; vblank = 1'b1;
    wr_x = '0; wr_y = '0; wr_z = '0;
    #12;
    chk("rst_ack", wr_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", cfg_valid, 0);
    chk("rst_upd", cfg_update, 0);
    chk("rst_zone", zone, 0);
    chk("rst_tx", trans_x, 0);
    chk("rst_bx", x_bound, 0);
    chk("rst_stride", line_stride, 0);
    @(negedge clk);
    rst = 1'b0;
    step;

    // Basic case and zone boundaries
    run_one("t1", 320, 240, 0);
    run_one("t2", 320, 240, 1000);
    run_one("z49", 320, 240, 49);
    run_one("z50", 320, 240, 50);
    run_one("z949", 320, 240, 949);
    run_one("z950", 320, 240, 950);
    run_one("wrap", 5, 240, 0);

    // Commit held off until vblank
    p_tx = e_tx; p_zone = e_zone;
    vblank = 1'b0;
    send(100, 100, 120, nb, nu);
    nu2 = nu;
    repeat (6) begin
      step;
      nu2 += int'(cfg_update);
    end
    chk("vb_no_upd", nu2, 0);
    chk("vb_hold_tx", trans_x, p_tx);
    chk("vb_hold_zone", zone, p_zone);
    chk("vb_idle", busy, 0);
    vblank = 1'b1;
    step;
    chk("vb_upd", cfg_update, 1);
    model(100, 100, 120);
    check_outputs("vb");

    // Capture and commit in the same cycle
    vblank = 1'b0;
    model(400, 300, 60);
    a_tx = e_tx; a_zone = e_zone;
    send(400, 300, 60, nb, nu);
    repeat (5) step;
    vblank = 1'b1;
    wr_x = 16'd150; wr_y = 16'd90; wr_z = 16'd260; wr_req = 1'b1;
    step;
    chk("cc_upd", cfg_update, 1);
    chk("cc_ack", wr_ack, 1);
    chk("cc_old_tx", trans_x, a_tx);
    chk("cc_old_zone", zone, a_zone);
    step;
    chk("cc_ack_once", wr_ack, 0);
    wr_req = 1'b0;
    model(150, 90, 260);
    wait_upd(60, cyc, nb);
    check_outputs("cc_new");

    // Second write mid-ZONE: only the last one commits
    step;
    send(600, 100, 900, nb, nu);
    nu2 = nu;
    repeat (3) begin
      step;
      nu2 += int'(cfg_update);
    end
    send(200, 150, 500, nb, nu);
    nu2 += nu;
    chk("mid_no_upd", nu2, 0);
    model(200, 150, 500);
    wait_upd(60, cyc, nb);
    check_outputs("mid");
    nu2 = 0;
    repeat (25) begin
      step;
      nu2 += int'(cfg_update);
    end
    chk("mid_single", nu2, 0);

    // Randomized positions
    for (int i = 0; i < 10; i++) begin
      int rx, ry, rz;
      rx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 65535));
      ry = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 65535));
      rz = int'($urandom_range(0, 1100));
      run_one("rnd", rx, ry, rz);
    end

    // Reset mid-ZONE
    send(320, 240, 900, nb, nu);
    repeat (3) step;
    rst = 1'b1;
    #1;
    chk("rst2_busy", busy, 0);
    chk("rst2_valid", cfg_valid, 0);
    chk("rst2_zone", zone, 0);
    chk("rst2_tx", trans_x, 0);
    chk("rst2_by", y_bound, 0);
    chk("rst2_stride", line_stride, 0);
    step;
    chk("rst2_busy_edge", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    nu2 = 0;
    repeat (25) begin
      step;
      nu2 += int'(cfg_update);
    end
    chk("rst2_no_commit", nu2, 0);
    chk("rst2_idle", busy, 0);
    run_one("after_rst", 1000, 700, 333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
